// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: multi-cycle signed mult/div holding the HI/LO registers.
// Operands are latched at start; HI/LO are written on the final busy edge.
module md_unit_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mult_E,
    input  logic        div_E,
    input  logic        mfhi_E,
    input  logic        mflo_E,
    input  logic [31:0] a_E,
    input  logic [31:0] b_E,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_E
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {OP_MUL, OP_DIV} op_t;

    state_t      state, state_d;
    op_t         op, op_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_d, lo_d;

    logic [63:0]        prod;
    logic signed [31:0] sa, sb, quot, rem;

    // Sign-extending to 64 bits makes the unsigned product equal the signed one.
    assign prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign sa   = a_q;
    assign sb   = b_q;

    // The overflow case is pinned explicitly so its result never depends on
    // how the tool treats a signed division that does not fit.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b_q == 32'h0) begin
            quot = '0;
            rem  = '0;
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            quot = sa;
            rem  = '0;
        end else begin
            quot = sa / sb;
            rem  = sa % sb;
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state;
        op_d    = op;
        cnt_d   = cnt;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state)
            IDLE: begin
                if (start && (mult_E ^ div_E)) begin
                    a_d     = a_E;
                    b_d     = b_E;
                    state_d = RUN;
                    if (mult_E) begin
                        op_d  = OP_MUL;
                        cnt_d = CW'(MULT_CYCLES);
                    end else begin
                        op_d  = OP_DIV;
                        cnt_d = CW'(DIV_CYCLES);
                    end
                end
            end
            RUN: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = IDLE;
                    if (op == OP_MUL) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'h0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values computed in the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op    <= OP_MUL;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_d;
            op    <= op_d;
            cnt   <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            hi    <= hi_d;
            lo    <= lo_d;
        end
    end

    assign busy   = (state == RUN);
    assign hilo_E = mfhi_E ? hi : (mflo_E ? lo : 32'h0);

endmodule

// File: tb/tb_md_unit_e.sv
// Directed self-checking bench for md_unit_e: mult/div results, busy length,
// ignored starts, divide-by-zero, overflow, reset abort and back-to-back issue.
module tb_md_unit_e;

    logic        clk = 1'b0;
    logic        reset, start, mult_E, div_E, mfhi_E, mflo_E;
    logic [31:0] a_E, b_E;
    logic        busy;
    logic [31:0] hi, lo, hilo_E;

    int passes = 0;
    int checks = 0;
    int n;

    md_unit_e dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mult_E (mult_E),
        .div_E  (div_E),
        .mfhi_E (mfhi_E),
        .mflo_E (mflo_E),
        .a_E    (a_E),
        .b_E    (b_E),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .hilo_E (hilo_E)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from now until busy drops, bounded.
    task automatic wait_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            step();
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        mult_E = m;
        div_E  = d;
        a_E    = a;
        b_E    = b;
        step();
        start  = 1'b0;
        mult_E = 1'b0;
        div_E  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mult_E = 1'b0; div_E = 1'b0;
        mfhi_E = 1'b0; mflo_E = 1'b0; a_E = '0; b_E = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_hilo", hilo_E, 32'h0);

        // mult 7 * -3
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_busy(n);
        check("mul_busy_len", n, 32'd5);
        check("mul_hi", hi, 32'hFFFF_FFFF);
        check("mul_lo", lo, 32'hFFFF_FFEB);
        mflo_E = 1'b1;
        #1 check("hilo_lo", hilo_E, 32'hFFFF_FFEB);
        mfhi_E = 1'b1;
        #1 check("hilo_hi_prio", hilo_E, 32'hFFFF_FFFF);
        mfhi_E = 1'b0; mflo_E = 1'b0;
        #1 check("hilo_none", hilo_E, 32'h0);

        // div -7 / 2
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_busy(n);
        check("div1_busy_len", n, 32'd10);
        check("div1_lo", lo, 32'hFFFF_FFFD);
        check("div1_hi", hi, 32'hFFFF_FFFF);

        // div 7 / -2
        issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_busy(n);
        check("div2_lo", lo, 32'hFFFF_FFFD);
        check("div2_hi", hi, 32'h1);

        // preload hi=0x11 lo=0x22: 0x66 * 0x2AAAAAAB = 0x11_00000022
        issue(1'b1, 1'b0, 32'h66, 32'h2AAA_AAAB);
        wait_busy(n);
        check("pre_hi", hi, 32'h11);
        check("pre_lo", lo, 32'h22);

        // div by zero keeps HI/LO but still takes the full latency
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        wait_busy(n);
        check("dz_busy_len", n, 32'd10);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        // overflow case
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // mult 3*4; a second start with new operands at busy cycle 2 is ignored
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        step();
        check("ign_busy_c2", {31'b0, busy}, 32'h1);
        issue(1'b0, 1'b1, 32'd100, 32'd3);
        a_E = 32'hDEAD_BEEF; b_E = 32'h1234_5678;
        wait_busy(n);
        check("ign_busy_rest", n, 32'd3);
        check("ign_lo", lo, 32'd12);
        check("ign_hi", hi, 32'd0);

        // div 100/7 aborted by reset at busy cycle 4
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        step(); step(); step();
        check("abort_busy_c4", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        for (int i = 0; i < 10; i++) step();
        check("abort_nowrite_hi", hi, 32'h0);
        check("abort_nowrite_lo", lo, 32'h0);
        check("abort_still_idle", {31'b0, busy}, 32'h0);

        // reset beats a simultaneous start; start with both op selects is ignored
        reset = 1'b1;
        issue(1'b1, 1'b0, 32'd9, 32'd9);
        reset = 1'b0;
        check("rst_wins", {31'b0, busy}, 32'h0);
        issue(1'b1, 1'b1, 32'd9, 32'd9);
        check("both_sel_ignored", {31'b0, busy}, 32'h0);
        issue(1'b0, 1'b0, 32'd9, 32'd9);
        check("no_sel_ignored", {31'b0, busy}, 32'h0);

        // back-to-back: mult 2*3, then div 100/7 issued in the cycle busy drops
        issue(1'b1, 1'b0, 32'd2, 32'd3);
        wait_busy(n);
        check("b2b_mul_lo", lo, 32'd6);
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        check("b2b_accepted", {31'b0, busy}, 32'h1);
        wait_busy(n);
        check("b2b_div_len", n, 32'd10);
        check("b2b_div_lo", lo, 32'd14);
        check("b2b_div_hi", hi, 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/md_unit_e.md
# md_unit_E

Multiply/divide unit in the E stage of the P6 pipeline; consumes `start`, `mult_E`, `div_E`, `mfhi_E` and `mflo_E` from the E-stage decoder, with forwarded operands rs/rt. Runs signed `mult` and `div` over multiple cycles and holds the HI/LO architectural registers. Exposes `busy` to the hazard unit and a HI/LO read value for the `mfhi`/`mflo` result mux.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`.
- `DIV_CYCLES`, 10: busy cycles for `div`.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a mult/div this cycle; qualified by `mult_E`/`div_E`.
- `mult_E` input 1: operation is signed multiply.
- `div_E` input 1: operation is signed divide.
- `mfhi_E` input 1: E-stage instruction reads HI.
- `mflo_E` input 1: E-stage instruction reads LO.
- `a_E` input 32: forwarded rs value.
- `b_E` input 32: forwarded rt value.
- `busy` output 1: operation in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `hilo_E` output 32: `mfhi_E ? hi : lo`, combinational; zero when neither select is high.

## Operation
- State: IDLE, RUN. A cycle counter `cnt` and an op register (MUL/DIV) are held. Operands are latched at start.
- IDLE, start=1, mult_E=1 -> latch a/b, op=MUL, cnt=MULT_CYCLES, go to RUN.
- IDLE, start=1, div_E=1 -> latch a/b, op=DIV, cnt=DIV_CYCLES, go to RUN.
- IDLE, start=1 with neither or both of mult_E/div_E -> ignored; stay IDLE.
- RUN: cnt decrements every edge. On the edge where cnt goes 1->0, HI/LO are written and the state returns to IDLE.
- `busy` = (state==RUN). It is registered and has no combinational path from `start`.
- A start while in RUN is ignored. The hazard unit never issues one, but the block does not rely on that.
- MUL: 64-bit signed product of the latched operands; hi=[63:32], lo=[31:0].
- DIV: lo = signed quotient, truncated toward zero; hi = signed remainder, with the sign of the dividend.
- DIV with b==0: HI and LO keep their prior values. The op still occupies DIV_CYCLES.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Result computation happens on the latched operands only. Changes on a_E/b_E during RUN have no effect.
- `hilo_E` always reflects the current registers. While busy, the old HI/LO are visible; mfhi/mflo ordering is the hazard unit's job.

## Timing
- Reset, any state: next edge forces state=IDLE, cnt=0, busy=0, hi=0, lo=0. Any in-flight op is discarded with no HI/LO write.
- reset and start in the same cycle: reset wins.
- Start sampled at edge T0. busy is high from T0+1 through T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo are updated at the edge ending cycle T0+N. New values are visible in the same cycle busy drops (T0+N+1).
- Back-to-back: a start in cycle T0+N+1 is accepted. Minimum issue interval is N+1 cycles.
- Hazard contract, documented here for verification: the hazard unit stalls D-stage mult/div/mfhi/mflo while `start | busy`.

## Test plan
- Reset, then start mult with a=7, b=0xFFFFFFFD (-3) -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; hilo_E=0xFFFFFFEB with mflo_E=1.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Preload hi=0x11, lo=0x22 via mult; div a=5, b=0 -> after 10 busy cycles hi=0x11, lo=0x22 unchanged. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start mult 3*4; at busy cycle 2 assert start with div_E=1 and change a_E/b_E -> second start ignored; busy ends after 5 cycles; lo=12, hi=0.
- Start div 100/7; assert reset at busy cycle 4 -> next cycle busy=0, hi=0, lo=0, and no later write. A start in the cycle immediately after the completing edge is accepted.
